// File: rtl/qupls_reg_alloc_banked_pkg.sv
// Shared types and default sizing for the banked physical-register allocator.
// The typedefs follow the default parameter set below.
package QuplsPkg;

  localparam int PREGS_DEF  = 256;
  localparam int NPORTS_DEF = 4;
  localparam int NFTAGS_DEF = 4;
  localparam int NCHKPT_DEF = 8;
  localparam int RSV0_DEF   = 1;

  localparam int PREG_W = $clog2(PREGS_DEF);
  localparam int CHK_W  = $clog2(NCHKPT_DEF);

  typedef logic [PREG_W-1:0] pregno_t;
  typedef logic [CHK_W-1:0]  chkid_t;

endpackage

// File: rtl/qupls_ffo_n.sv
// Find-first-one: index of the lowest set bit of vec, plus a non-zero flag.
module qupls_ffo_n #(
  parameter int W  = 64,
  parameter int IW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  vec,
  output logic [IW-1:0] idx,
  output logic          found
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx   = '0;
    found = |vec;
    for (int i = W - 1; i >= 0; i--) begin
      if (vec[i]) idx = IW'(i);
    end
  end

endmodule

// File: rtl/qupls_reg_alloc_banked.sv
// Banked physical-register free-list allocator with checkpoints, double-free
// detection and a free-register count. Alloc port p only draws from bank p.
module qupls_reg_alloc_banked
  import QuplsPkg::*;
#(
  parameter int PREGS  = PREGS_DEF,
  parameter int NPORTS = NPORTS_DEF,
  parameter int NFTAGS = NFTAGS_DEF,
  parameter int NCHKPT = NCHKPT_DEF,
  parameter int RSV0   = RSV0_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NPORTS-1:0]        alloc_req,
  output logic [NPORTS-1:0]        alloc_ok,
  output pregno_t [NPORTS-1:0]     wo,
  output logic                     stall,
  input  pregno_t [NFTAGS-1:0]     tags2free,
  input  logic [NFTAGS-1:0]        freevals,
  input  logic [PREGS-1:0]         list2free,
  input  logic                     chk_save,
  input  logic                     chk_restore,
  input  chkid_t                   chk_id,
  output logic [PREGS-1:0]         avail,
  output logic [$clog2(PREGS):0]   free_cnt,
  output logic                     err_dfree
);

  localparam int BSZ = PREGS / NPORTS;
  localparam int IW  = (BSZ > 1) ? $clog2(BSZ) : 1;
  localparam int CW  = $clog2(PREGS) + 1;
  // Preg 0 is excluded from both allocation and freeing when reserved.
  localparam logic [PREGS-1:0] RSV_MASK  = PREGS'(RSV0);
  localparam logic [PREGS-1:0] RST_AVAIL = ~RSV_MASK;

  logic [PREGS-1:0]              avail_q, avail_d;
  logic [PREGS-1:0]              slot_q [NCHKPT];
  logic [PREGS-1:0]              slot_d [NCHKPT];
  logic [NPORTS-1:0]             alloc_ok_q, alloc_ok_d;
  pregno_t [NPORTS-1:0]          wo_q, wo_d;
  logic                          stall_q, stall_d;
  logic [CW-1:0]                 free_cnt_q, free_cnt_d;
  logic                          err_q, err_d;

  logic [NPORTS-1:0][IW-1:0]     ffo_idx;
  logic [NPORTS-1:0]             ffo_found;
  pregno_t [NPORTS-1:0]          bank_tag;
  logic                          grant;
  logic [PREGS-1:0]              allocbits;
  logic [PREGS-1:0]              freebits;

  // One lowest-free-register search per bank, working on registered avail.
  generate
    for (genvar gi = 0; gi < NPORTS; gi++) begin : g_bank
      qupls_ffo_n #(.W(BSZ), .IW(IW)) u_ffo (
        .vec   (avail_q[gi*BSZ +: BSZ]),
        .idx   (ffo_idx[gi]),
        .found (ffo_found[gi])
      );
      assign bank_tag[gi] = pregno_t'(gi * BSZ) + pregno_t'(ffo_idx[gi]);
    end
  endgenerate

  // All-or-nothing grant: every requesting port needs a free reg in its bank.
  always_comb begin
    grant     = (|alloc_req) && !chk_restore && (&(ffo_found | ~alloc_req));
    allocbits = '0;
    for (int p = 0; p < NPORTS; p++) begin
      if (grant && alloc_req[p]) allocbits[bank_tag[p]] = 1'b1;
    end
  end

  // Merge individually tagged frees with the bulk flush bitmap.
  always_comb begin
    freebits = list2free;
    for (int n = 0; n < NFTAGS; n++) begin
      if (freevals[n]) freebits[tags2free[n]] = 1'b1;
    end
    freebits = freebits & ~RSV_MASK;
  end

  // Next free list, checkpoints, grant outputs and popcount.
  always_comb begin
    if (chk_restore) avail_d = slot_q[chk_id] | freebits;
    else             avail_d = (avail_q & ~allocbits) | freebits;

    err_d = err_q | (|(freebits & avail_q));

    // Frees are folded into every snapshot so they survive a later restore.
    for (int c = 0; c < NCHKPT; c++) slot_d[c] = slot_q[c] | freebits;
    if (chk_save && !chk_restore) slot_d[chk_id] = avail_d;

    wo_d = wo_q;
    if (grant) begin
      alloc_ok_d = alloc_req;
      stall_d    = 1'b0;
      for (int p = 0; p < NPORTS; p++) begin
        if (alloc_req[p]) wo_d[p] = bank_tag[p];
      end
    end else begin
      alloc_ok_d = '0;
      stall_d    = |alloc_req;
    end

    free_cnt_d = '0;
    for (int i = 0; i < PREGS; i++) free_cnt_d = free_cnt_d + CW'(avail_d[i]);
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      avail_q    <= RST_AVAIL;
      alloc_ok_q <= '0;
      wo_q       <= '0;
      stall_q    <= 1'b0;
      free_cnt_q <= CW'(PREGS - RSV0);
      err_q      <= 1'b0;
      for (int c = 0; c < NCHKPT; c++) slot_q[c] <= RST_AVAIL;
    end else begin
      avail_q    <= avail_d;
      alloc_ok_q <= alloc_ok_d;
      wo_q       <= wo_d;
      stall_q    <= stall_d;
      free_cnt_q <= free_cnt_d;
      err_q      <= err_d;
      for (int c = 0; c < NCHKPT; c++) slot_q[c] <= slot_d[c];
    end
  end

  assign avail     = avail_q;
  assign alloc_ok  = alloc_ok_q;
  assign wo        = wo_q;
  assign stall     = stall_q;
  assign free_cnt  = free_cnt_q;
  assign err_dfree = err_q;

endmodule

// File: doc/qupls_reg_alloc_banked.md
Name: qupls_reg_alloc_banked

Overview:
Parametrised physical-register free-list allocator for the Qupls rename stage. The physical register file is split into NPORTS equal banks, and alloc port p draws only from bank p. A port group is granted atomically or stalled as a whole. The block adds checkpoint save/restore for branch-miss recovery, double-free detection and a free-register count. It sits between decode and the rename map; it is fed frees from commit and the flush logic.

Parameters:
PREGS, 256, physical register count; must be a multiple of NPORTS.
NPORTS, 4, allocation ports (= banks); bank size BSZ = PREGS/NPORTS.
NFTAGS, 4, individually tagged frees per cycle.
NCHKPT, 8, checkpoint slots.
RSV0, 1, when 1, preg 0 is never allocated or freed.

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
alloc_req  in  NPORTS  per-port allocation request
alloc_ok  out  NPORTS  registered grant; wo[p] valid when set
wo  out  NPORTS x pregno_t  allocated tag for port p; bank-p range only
stall  out  1  registered; requested group could not be granted
tags2free  in  NFTAGS x pregno_t  tags to free
freevals  in  NFTAGS  valid mask for tags2free
list2free  in  PREGS  bulk free bitmap (flush path)
chk_save  in  1  snapshot the free list into slot chk_id
chk_restore  in  1  restore the free list from slot chk_id
chk_id  in  $clog2(NCHKPT)  checkpoint slot index
avail  out  PREGS  current free bitmap (recorded in ROB)
free_cnt  out  $clog2(PREGS)+1  popcount of avail, registered
err_dfree  out  1  sticky; a free targeted an already-free register

Behaviour:
- Reset (rst=0, async): avail = all ones, bit 0 cleared if RSV0. Outputs cleared: wo=0, alloc_ok=0, stall=0, err_dfree=0. free_cnt = PREGS-RSV0. All checkpoint slots = reset avail.
- Per bank b: find-first-one on avail[b*BSZ +: BSZ]. Result is tag {b, index}. found[b] = slice non-zero.
- Grant, all-or-nothing: grant = |alloc_req && !chk_restore && every requested port's bank is found.
- If grant: alloc_ok <= alloc_req, wo[p] <= tag for each requested p, stall <= 0, and the allocated bits are cleared in next avail.
- If not granted with a non-zero request (bank empty or restore): alloc_ok <= 0, stall <= 1, wo held.
- With no request: alloc_ok <= 0, stall <= 0.
- Latency is 1 clock from request to alloc_ok/wo.
- freebits = OR over n of (freevals[n] << tags2free[n]), OR list2free. Bit 0 is masked when RSV0.
- Next avail = (avail & ~allocbits) | freebits. A bit freed this cycle is not allocatable until the following cycle, because the FFO reads registered avail.
- Double free: any freebits bit already set in avail sets err_dfree (sticky until reset). The free is still applied as an idempotent OR.
- Each cycle, every checkpoint slot ORs in freebits, so commits after a snapshot stay free after a restore.
- chk_save: slot[chk_id] <= next avail, which includes this cycle's allocations and frees.
- chk_restore: avail <= slot[chk_id] | freebits. Allocation is suppressed that cycle.
- chk_save and chk_restore in the same cycle: restore wins and the save is dropped.
- free_cnt <= popcount(next avail), so it tracks avail with no extra lag.
- Bank exhaustion is local. A request on an empty bank stalls the whole group even if other banks have free registers.

Decomposition:
- QuplsPkg holds pregno_t and PREGS-derived widths; add typedef chkid_t.
- Sub-module qupls_ffo_n: parametrised width BSZ, outputs index and found. Instantiate NPORTS times via generate.
- Popcount and checkpoint array stay inline.

Test Plan:
1. Reset release, alloc_req=4'b1111 with PREGS=256/NPORTS=4 -> next cycle alloc_ok=1111, wo={192,128,64,1}, free_cnt=251.
2. Drain bank 2 with 64 requests on port 2 only, then request 4'b0101 -> alloc_ok=0000, stall=1, avail unchanged. Free tag 130 -> the next cycle's grant gives wo[2]=130.
3. chk_save slot 3, allocate 4 regs, commit-free tag 5 (allocated before the save), then chk_restore slot 3 -> avail equals the snapshot | bit5, and alloc_ok=0 that cycle.
4. Same-cycle chk_save slot 1 and chk_restore slot 1 -> restore applied and slot 1 keeps its old contents.
5. Free tag 200 while it is already free -> err_dfree=1 next cycle and stays set; free_cnt unchanged.
6. Assert rst mid-stream with alloc_req held high -> all outputs clear immediately (async); the first post-reset grant matches scenario 1.
